ssd_scan_ctrl: RTL

- Parametrised N-digit multiplexed seven-segment scanner. It replaces ad-hoc per-top SSD scan/decode logic.
- Takes a packed hex nibble vector plus decimal-point and digit-enable masks. Drives active-low anodes and cathodes {Ca..Cg,Dp}.
- Adds behaviour the ad-hoc logic lacks: tear-free frame-synchronous loading, inter-digit ghost blanking, PWM brightness and leading-zero suppression.
- Sits in vga_top-level designs between game/control logic and board SSD pins.

---
 rtl/ssd_scan_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scan_ctrl
//  Purpose  : N-digit multiplexed seven-segment scanner with frame-synchronous
//             shadow loading, ghost blanking, PWM dimming and leading-zero blanking.
//  Revision : 1.0  initial release
// ============================================================================
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_CYCLES  = 262144,
    parameter int BLANK_CYCLES = 64,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [4*NUM_DIGITS-1:0]       Digits,
    input  logic [NUM_DIGITS-1:0]         Dp_in,
    input  logic [NUM_DIGITS-1:0]         Digit_en,
    input  logic                          Lz_suppress,
    input  logic [BRIGHT_BITS-1:0]        Brightness,
    input  logic                          Load,
    output logic [NUM_DIGITS-1:0]         An,
    output logic [7:0]                    Cathodes,
    output logic [$clog2(NUM_DIGITS)-1:0] Scan_idx,
    output logic                          Frame_start,
    output logic                          Load_pending
);

    localparam int TICK_W = $clog2(SCAN_CYCLES);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(SCAN_CYCLES - 1);
    localparam logic [TICK_W-1:0] BLANK_END = TICK_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BRIGHT_BITS-1:0]  pwm_q;
    logic                    frame_start_q, frame_start_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] sh_dig_q;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_en_q, sh_sup_q, sup_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              cath_q, cath_d;

    logic       slot_end, frame_wrap, capture;
    logic       lead;
    logic [3:0] cur_nib;
    logic       cur_dp, cur_en, cur_sup, pwm_on, visible;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    assign slot_end   = (tick_q == LAST_TICK);
    assign frame_wrap = slot_end & (idx_q == LAST_IDX);
    // A Load landing on the wrap cycle itself is captured on that same edge.
    assign capture    = frame_wrap & (pend_q | Load);

    always_comb begin
        tick_d        = slot_end ? '0 : tick_q + 1'b1;
        idx_d         = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        frame_start_d = frame_wrap;
        pend_d        = capture ? 1'b0 : (pend_q | Load);
    end

    // Leading-zero mask, walked from the most significant digit downwards.
    always_comb begin
        sup_d = '0;
        lead  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            sup_d[k] = Lz_suppress & lead & (Digits[4*k +: 4] == 4'h0) & ~Dp_in[k];
            lead     = lead & (~Digit_en[k] | sup_d[k]);
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_sup = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib = sh_dig_q[4*k +: 4];
                cur_dp  = sh_dp_q[k];
                cur_en  = sh_en_q[k];
                cur_sup = sh_sup_q[k];
            end
        end
    end

    assign pwm_on  = (&Brightness) | (pwm_q < Brightness);
    assign visible = cur_en & ~cur_sup & pwm_on & (tick_q >= BLANK_END);

    always_comb begin
        an_d   = '1;
        cath_d = 8'hFF;
        if (visible) begin
            an_d[idx_q] = 1'b0;
            cath_d      = {hex7(cur_nib), ~cur_dp};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_q        <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            pend_q        <= 1'b0;
            sh_dig_q      <= '0;
            sh_dp_q       <= '0;
            sh_en_q       <= '0;
            sh_sup_q      <= '0;
            an_q          <= '1;
            cath_q        <= 8'hFF;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_q + 1'b1;
            frame_start_q <= frame_start_d;
            pend_q        <= pend_d;
            an_q          <= an_d;
            cath_q        <= cath_d;
            if (capture) begin
                sh_dig_q <= Digits;
                sh_dp_q  <= Dp_in;
                sh_en_q  <= Digit_en;
                sh_sup_q <= sup_d;
            end
        end
    end

    assign An           = an_q;
    assign Cathodes     = cath_q;
    assign Scan_idx     = idx_q;
    assign Frame_start  = frame_start_q;
    assign Load_pending = pend_q;

endmodule
`default_nettype wire
